// File: rtl/wrapper_pkg.sv
// Shared definitions for the FP input wrapper: controller states, default
// bus/operand widths and the transfers-per-pair helper.
package wrapper_pkg;

  localparam int unsigned BUS_W_DEF  = 8;
  localparam int unsigned WORD_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ACK   = 3'd2,
    ST_START = 3'd3,
    ST_BUSY  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  // Bus transfers needed to assemble both operands.
  function automatic int unsigned nxfer(input int unsigned bus_w,
                                        input int unsigned word_w);
    return (2 * word_w) / bus_w;
  endfunction

endpackage

// File: rtl/wrapper_in_cu.sv
// Controller for the FP input wrapper: four-phase byte handshake, start
// pulse and hold-off until the FP core signals completion.
module wrapper_in_cu
  import wrapper_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inReady,
  input  logic doneFP,
  input  logic last,
  output logic loadByte,
  output logic clrCnt,
  output logic inAccepted,
  output logic startFP,
  output logic busy
);

  state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    loadByte   = 1'b0;
    clrCnt     = 1'b0;
    inAccepted = 1'b0;
    startFP    = 1'b0;
    busy       = 1'b0;
    unique case (state)
      ST_IDLE: if (inReady) state_nxt = ST_LOAD;
      ST_LOAD: begin
        loadByte  = 1'b1;
        state_nxt = ST_ACK;
      end
      ST_ACK: begin
        inAccepted = 1'b1;
        if (!inReady) state_nxt = last ? ST_START : ST_IDLE;
      end
      ST_START: begin
        startFP   = 1'b1;
        clrCnt    = 1'b1;
        state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (doneFP) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Wait out a multi-cycle doneFP so it cannot restart the core.
        busy = 1'b1;
        if (!doneFP) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/wrapper_in_dp.sv
// Operand datapath: {OpA,OpB} left shift register fed from the input bus,
// plus the transfer counter that flags a complete operand pair.
module wrapper_in_dp
  import wrapper_pkg::*;
#(
  parameter int unsigned BUS_W  = BUS_W_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_W-1:0]  InBus,
  input  logic              loadByte,
  input  logic              clrCnt,
  output logic              last,
  output logic [WORD_W-1:0] OpA,
  output logic [WORD_W-1:0] OpB
);

  localparam int unsigned NXFER = nxfer(BUS_W, WORD_W);
  localparam int unsigned CNT_W = $clog2(NXFER) + 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OpA <= '0;
      OpB <= '0;
    end else if (loadByte) begin
      {OpA, OpB} <= {OpA[WORD_W-BUS_W-1:0], OpB, InBus};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clrCnt) begin
      cnt <= '0;
    end else if (loadByte) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(NXFER));

endmodule

// File: rtl/wrapper_in_fp.sv
// Input wrapper for the FP unit: assembles operands A and B byte-serially
// and hands them to the FP core with a one-cycle start pulse.
module wrapper_in_fp
  import wrapper_pkg::*;
#(
  parameter int unsigned BUS_W  = BUS_W_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_W-1:0]  InBus,
  input  logic              inReady,
  input  logic              doneFP,
  output logic              inAccepted,
  output logic              startFP,
  output logic              busy,
  output logic [WORD_W-1:0] OpA,
  output logic [WORD_W-1:0] OpB
);

  logic loadByte;
  logic clrCnt;
  logic last;

  wrapper_in_dp #(
    .BUS_W  (BUS_W),
    .WORD_W (WORD_W)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .InBus    (InBus),
    .loadByte (loadByte),
    .clrCnt   (clrCnt),
    .last     (last),
    .OpA      (OpA),
    .OpB      (OpB)
  );

  wrapper_in_cu u_cu (
    .clk        (clk),
    .rst        (rst),
    .inReady    (inReady),
    .doneFP     (doneFP),
    .last       (last),
    .loadByte   (loadByte),
    .clrCnt     (clrCnt),
    .inAccepted (inAccepted),
    .startFP    (startFP),
    .busy       (busy)
  );

endmodule

// File: tb/tb_wrapper_in_fp.sv
// Directed bench for wrapper_in_fp: handshake, operand assembly, start pulse,
// Busy/Drain hold-off and asynchronous reset abort.
module tb_wrapper_in_fp;

  logic        clk;
  logic        rst;
  logic [7:0]  InBus;
  logic        inReady;
  logic        doneFP;
  logic        inAccepted;
  logic        startFP;
  logic        busy;
  logic [31:0] OpA;
  logic [31:0] OpB;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  wrapper_in_fp #(
    .BUS_W  (8),
    .WORD_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .InBus      (InBus),
    .inReady    (inReady),
    .doneFP     (doneFP),
    .inAccepted (inAccepted),
    .startFP    (startFP),
    .busy       (busy),
    .OpA        (OpA),
    .OpB        (OpB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (startFP === 1'b1) starts++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bounded wait (in negedges) for inAccepted to reach lvl.
  task automatic wait_acc(input logic lvl, input string tag);
    int n = 0;
    while (inAccepted !== lvl && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, inAccepted}, {31'd0, lvl});
  endtask

  // Four-phase transfer of one byte; extra = additional Ack cycles held.
  task automatic send_byte(input logic [7:0] b, input int extra);
    logic [31:0] snap;
    InBus   = b;
    inReady = 1'b1;
    @(negedge clk);
    wait_acc(1'b1, "acc_up");
    snap = OpB;
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      chk("acc_hold", {31'd0, inAccepted}, 32'd1);
      chk("hold_opb", OpB, snap);
    end
    inReady = 1'b0;
    @(negedge clk);
    wait_acc(1'b0, "acc_dn");
  endtask

  task automatic send_pair(input logic [63:0] w, input int slow_idx, input int slow_extra);
    for (int i = 0; i < 8; i++)
      send_byte(w[63-8*i -: 8], (i == slow_idx) ? slow_extra : 0);
    chk("start_hi", {31'd0, startFP}, 32'd1);
    chk("busy_lo_start", {31'd0, busy}, 32'd0);
    chk("opa", OpA, w[63:32]);
    chk("opb", OpB, w[31:0]);
    @(negedge clk);
    chk("start_lo", {31'd0, startFP}, 32'd0);
    chk("busy_hi", {31'd0, busy}, 32'd1);
  endtask

  task automatic done_pulse();
    doneFP = 1'b1;
    @(negedge clk);
    doneFP = 1'b0;
    @(negedge clk);
    chk("busy_end", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; InBus = '0; inReady = 1'b0; doneFP = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_acc", {31'd0, inAccepted}, 32'd0);
    chk("rst_start", {31'd0, startFP}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_opa", OpA, 32'd0);
    rst = 1'b0;

    // Reset in the middle of Load discards the byte.
    InBus = 8'h55; inReady = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("rstload_acc", {31'd0, inAccepted}, 32'd0);
    chk("rstload_busy", {31'd0, busy}, 32'd0);
    chk("rstload_opa", OpA, 32'd0);
    chk("rstload_opb", OpB, 32'd0);
    inReady = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rstload_opb2", OpB, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Pair with a slow source on byte 3.
    send_pair(64'h40000000_3F800000, 3, 4);
    repeat (2) begin
      @(negedge clk);
      chk("busy_wait", {31'd0, busy}, 32'd1);
    end

    // Source offers 0xAA while the core is busy: must stall.
    InBus = 8'hAA; inReady = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_acc", {31'd0, inAccepted}, 32'd0);
    end
    chk("stall_opa", OpA, 32'h40000000);
    chk("stall_opb", OpB, 32'h3F800000);

    // doneFP held 4 cycles: stays busy, no restart.
    doneFP = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("drain_busy", {31'd0, busy}, 32'd1);
      chk("drain_start", {31'd0, startFP}, 32'd0);
      chk("drain_acc", {31'd0, inAccepted}, 32'd0);
    end
    doneFP = 1'b0;
    @(negedge clk);
    chk("busy_drop", {31'd0, busy}, 32'd0);
    chk("one_start", starts, 32'd1);

    // Pending 0xAA is now taken as the first byte of the next pair.
    wait_acc(1'b1, "aa_acc");
    chk("aa_opa", OpA, 32'h0000003F);
    chk("aa_opb", OpB, 32'h800000AA);
    inReady = 1'b0;
    @(negedge clk);
    wait_acc(1'b0, "aa_dn");
    for (int i = 1; i < 8; i++) send_byte(8'(i), 0);
    chk("aa_start", {31'd0, startFP}, 32'd1);
    chk("aa_pair_a", OpA, 32'hAA010203);
    chk("aa_pair_b", OpB, 32'h04050607);
    @(negedge clk);
    done_pulse();
    chk("two_starts", starts, 32'd2);

    // Reset during Ack of the 5th byte aborts the partial pair.
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    InBus = 8'h9A; inReady = 1'b1;
    @(negedge clk);
    wait_acc(1'b1, "r5_acc");
    rst = 1'b1; #1;
    chk("r5_acc_async", {31'd0, inAccepted}, 32'd0);
    chk("r5_opa", OpA, 32'd0);
    chk("r5_opb", OpB, 32'd0);
    inReady = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send_pair(64'h3FA00000_3F800000, -1, 0);
    done_pulse();
    chk("three_starts", starts, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
